muntjac_btb_assoc: RTL and testbench
====================================

MUNTJAC_BTB_ASSOC -- requirements
Module: muntjac_btb_assoc

Interface
REQ-001 Parameter AddrLen, default 64, PC/target width in bits.
REQ-002 Parameter IndexWidth, default 6, set index bits; the BTB has 2**IndexWidth sets.
REQ-003 Parameter NumWays, default 2, ways per set; legal range 1..8.
REQ-004 Port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 Port flush_i, input, 1, invalidates every entry.
REQ-007 Port train_valid_i, input, 1, training request this cycle.
REQ-008 Port train_branch_type_i, input, branch_type_e, type of the trained branch.
REQ-009 Port train_pc_i, input, AddrLen, PC of the trained branch.
REQ-010 Port train_partial_i, input, 1, branch straddles a fetch word.
REQ-011 Port train_npc_i, input, AddrLen, resolved target; bit 0 is ignored.
REQ-012 Port train_taken_i, input, 1, resolved direction.
REQ-013 Port access_valid_i, input, 1, lookup request this cycle.
REQ-014 Port access_pc_i, input, AddrLen, lookup PC.
REQ-015 Port access_hit_o, output, 1, lookup hit.
REQ-016 Port access_branch_type_o, output, branch_type_e, stored type.
REQ-017 Port access_partial_o, output, 1, stored partial flag.
REQ-018 Port access_npc_o, output, AddrLen, stored target with bit 0 forced to 0.

Function
REQ-019 Index = pc[2 +: IndexWidth]; tag = pc[AddrLen-1 : IndexWidth+2].
REQ-020 Storage is flops: per entry a valid bit, tag, partial, target[AddrLen-1:1] and branch_type.
REQ-021 Lookup latency is 1 cycle: outputs register the result of the access_valid_i cycle and hold while access_valid_i is low.
REQ-022 A hit requires a valid entry with a matching tag in the indexed set. On a hit, outputs carry that entry; on a miss, access_hit_o=0 and the other outputs are 0.
REQ-023 A lookup sees pre-write state: a train to the same set in the same cycle is not visible until the next lookup.
REQ-024 Train on a tag hit overwrites the hitting way in place; the replacement pointer is unchanged.
REQ-025 Train on a miss allocates the lowest-numbered invalid way. If none is invalid, it allocates the way named by the set's round-robin pointer, and that pointer then increments modulo NumWays.
REQ-026 The design holds at most one valid entry per (set, tag) at any time.
REQ-027 flush_i clears all valid bits in one cycle and leaves replacement pointers unchanged.
REQ-028 flush_i has priority: a train in the same cycle is dropped, and a lookup in the same cycle returns a miss.

Reset
REQ-029 Reset clears all valid bits, replacement pointers and output registers; access_hit_o reads 0 from reset until the first hit.
REQ-030 Reset asserted mid-operation discards any in-flight lookup or train with no partial update.

Configuration
REQ-031 With MUNTJAC_BTB_HYSTERESIS_EN defined:
- Each entry holds a 2-bit saturating counter.
- A miss-train allocates only when train_taken_i=1, with the counter initialised to 2.
- A hit-train increments the counter (saturating at 3) when taken and decrements it (saturating at 0) when not taken.
- Target, type and partial are rewritten only when taken.
- access_hit_o also requires counter >= 2.
REQ-032 Without MUNTJAC_BTB_HYSTERESIS_EN, no counters are built, train_taken_i is ignored, and every train writes the entry.

Structure
REQ-033 branch_type_e and the entry struct type live in muntjac_pkg.
REQ-034 The per-set victim selection (invalid-first, else round-robin) is sub-module muntjac_btb_victim_sel.

Verification
REQ-035 After reset, a lookup of PC 0x1000 -> access_hit_o=0 one cycle later.
REQ-036 Train pc=0x1000, npc=0x2001, then look up 0x1000 -> hit, access_npc_o=0x2000.
REQ-037 NumWays=2: train three PCs that alias to the same set with distinct tags (A, B, C), then look up each -> C evicts A; B and C hit, A misses. A fourth alias D then evicts B.
REQ-038 Train A, flush_i for 1 cycle, then look up A -> miss. A train of B during the flush cycle is dropped, so a later lookup of B misses.
REQ-039 Train A and look up A in the same cycle on an empty BTB -> miss; the next lookup of A hits.
REQ-040 With MUNTJAC_BTB_HYSTERESIS_EN: train A taken, then A not-taken -> lookup misses (counter=1); train A taken -> lookup hits (counter=2).

Source files
------------

// File: rtl/muntjac_pkg.sv
// Shared types for the Muntjac branch target buffer.
// Entries carry a 2-bit confidence counter only when MUNTJAC_BTB_HYSTERESIS_EN is defined.
package muntjac_pkg;

  localparam int unsigned BtbMaxAddrLen = 64;

  typedef enum logic [2:0] {
    BRANCH_NONE  = 3'd0,
    BRANCH_JUMP  = 3'd1,
    BRANCH_CALL  = 3'd2,
    BRANCH_RET   = 3'd3,
    BRANCH_YIELD = 3'd4,
    BRANCH_IRET  = 3'd5
  } branch_type_e;

  // Tag and target are held at the maximum width; unused upper bits stay zero.
  typedef struct packed {
    logic                     valid;
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
    logic [1:0]               counter;
`endif
    logic                     partial;
    branch_type_e             branch_type;
    logic [BtbMaxAddrLen-1:0] tag;
    logic [BtbMaxAddrLen-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/muntjac_btb_victim_sel.sv
// Per-set victim selection: the lowest-numbered invalid way, or the
// round-robin way when every way is occupied.
module muntjac_btb_victim_sel #(
  parameter int unsigned NumWays = 2,
  parameter int unsigned WayW    = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic [NumWays-1:0] valid,
  input  logic [WayW-1:0]    rr_ptr,
  output logic [WayW-1:0]    victim,
  output logic               all_valid
);

  // Scanning downwards lets the lowest invalid way win.
  always_comb begin
    all_valid = &valid;
    victim    = rr_ptr;
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (!valid[i]) victim = WayW'(i);
    end
  end

endmodule

// File: rtl/muntjac_btb_assoc.sv
// Set-associative branch target buffer with one-cycle registered lookup.
// Optional feature macro: MUNTJAC_BTB_HYSTERESIS_EN (2-bit confidence counters).
module muntjac_btb_assoc
  import muntjac_pkg::*;
#(
  parameter int unsigned AddrLen    = 64,
  parameter int unsigned IndexWidth = 6,
  parameter int unsigned NumWays    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               train_valid_i,
  input  branch_type_e       train_branch_type_i,
  input  logic [AddrLen-1:0] train_pc_i,
  input  logic               train_partial_i,
  input  logic [AddrLen-1:0] train_npc_i,
  input  logic               train_taken_i,
  input  logic               access_valid_i,
  input  logic [AddrLen-1:0] access_pc_i,
  output logic               access_hit_o,
  output branch_type_e       access_branch_type_o,
  output logic               access_partial_o,
  output logic [AddrLen-1:0] access_npc_o
);

  localparam int unsigned NumSets = 2 ** IndexWidth;
  localparam int unsigned WayW    = (NumWays > 1) ? $clog2(NumWays) : 1;

  btb_entry_t      entries_q [NumSets][NumWays];
  logic [WayW-1:0] rr_q      [NumSets];

  logic [IndexWidth-1:0]    train_idx, access_idx;
  logic [BtbMaxAddrLen-1:0] train_tag, access_tag, train_target;

  assign train_idx    = train_pc_i[2 +: IndexWidth];
  assign access_idx   = access_pc_i[2 +: IndexWidth];
  assign train_tag    = BtbMaxAddrLen'(train_pc_i[AddrLen-1:IndexWidth+2]);
  assign access_tag   = BtbMaxAddrLen'(access_pc_i[AddrLen-1:IndexWidth+2]);
  assign train_target = BtbMaxAddrLen'({train_npc_i[AddrLen-1:1], 1'b0});

  logic unused_bits;
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
  assign unused_bits = ^{train_pc_i[1:0], access_pc_i[1:0], train_npc_i[0]};
`else
  assign unused_bits = ^{train_pc_i[1:0], access_pc_i[1:0], train_npc_i[0], train_taken_i};
`endif

  logic [NumWays-1:0] train_valid_vec;
  logic               train_hit, all_valid;
  logic [WayW-1:0]    train_hit_way, victim_way, train_way;

  always_comb begin
    train_valid_vec = '0;
    train_hit       = 1'b0;
    train_hit_way   = '0;
    for (int unsigned w = 0; w < NumWays; w++) begin
      train_valid_vec[w] = entries_q[train_idx][w].valid;
      if (entries_q[train_idx][w].valid && entries_q[train_idx][w].tag == train_tag) begin
        train_hit     = 1'b1;
        train_hit_way = WayW'(w);
      end
    end
  end

  muntjac_btb_victim_sel #(
    .NumWays (NumWays),
    .WayW    (WayW)
  ) u_victim_sel (
    .valid     (train_valid_vec),
    .rr_ptr    (rr_q[train_idx]),
    .victim    (victim_way),
    .all_valid (all_valid)
  );

  assign train_way = train_hit ? train_hit_way : victim_way;

  btb_entry_t new_entry, fresh_entry;
  logic       train_we, rr_advance;

  always_comb begin
    fresh_entry             = entries_q[train_idx][train_way];
    fresh_entry.valid       = 1'b1;
    fresh_entry.tag         = train_tag;
    fresh_entry.partial     = train_partial_i;
    fresh_entry.branch_type = train_branch_type_i;
    fresh_entry.target      = train_target;
    new_entry  = entries_q[train_idx][train_way];
    train_we   = 1'b0;
    rr_advance = 1'b0;
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
    // Not-taken trains only weaken an existing entry and never allocate.
    if (train_valid_i && train_hit) begin
      train_we = 1'b1;
      if (train_taken_i) begin
        new_entry         = fresh_entry;
        new_entry.counter = (fresh_entry.counter == 2'd3) ? 2'd3 : fresh_entry.counter + 2'd1;
      end else begin
        new_entry.counter = (new_entry.counter == 2'd0) ? 2'd0 : new_entry.counter - 2'd1;
      end
    end else if (train_valid_i && train_taken_i) begin
      train_we          = 1'b1;
      new_entry         = fresh_entry;
      new_entry.counter = 2'd2;
      rr_advance        = all_valid;
    end
`else
    if (train_valid_i) begin
      train_we   = 1'b1;
      new_entry  = fresh_entry;
      rr_advance = !train_hit && all_valid;
    end
`endif
  end

  logic       access_hit;
  btb_entry_t access_entry;

  always_comb begin
    access_hit   = 1'b0;
    access_entry = '0;
    for (int unsigned w = 0; w < NumWays; w++) begin
      if (entries_q[access_idx][w].valid && entries_q[access_idx][w].tag == access_tag
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
          && entries_q[access_idx][w].counter[1]
`endif
          ) begin
        access_hit   = 1'b1;
        access_entry = entries_q[access_idx][w];
      end
    end
  end

  // Lookup results come from pre-write state; flush wins over train and lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NumSets; s++) begin
        rr_q[s] <= '0;
        for (int unsigned w = 0; w < NumWays; w++) entries_q[s][w] <= '0;
      end
      access_hit_o         <= 1'b0;
      access_branch_type_o <= BRANCH_NONE;
      access_partial_o     <= 1'b0;
      access_npc_o         <= '0;
    end else begin
      if (access_valid_i) begin
        if (access_hit && !flush_i) begin
          access_hit_o         <= 1'b1;
          access_branch_type_o <= access_entry.branch_type;
          access_partial_o     <= access_entry.partial;
          access_npc_o         <= access_entry.target[AddrLen-1:0];
        end else begin
          access_hit_o         <= 1'b0;
          access_branch_type_o <= BRANCH_NONE;
          access_partial_o     <= 1'b0;
          access_npc_o         <= '0;
        end
      end
      if (flush_i) begin
        for (int unsigned s = 0; s < NumSets; s++) begin
          for (int unsigned w = 0; w < NumWays; w++) entries_q[s][w].valid <= 1'b0;
        end
      end else if (train_we) begin
        entries_q[train_idx][train_way] <= new_entry;
        if (rr_advance) begin
          rr_q[train_idx] <= (rr_q[train_idx] == WayW'(NumWays - 1)) ? '0 : rr_q[train_idx] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muntjac_btb_assoc.sv
// Self-checking bench for muntjac_btb_assoc: directed cases plus random traffic
// checked against a per-set reference model (honours MUNTJAC_BTB_HYSTERESIS_EN).
module tb_muntjac_btb_assoc;
  import muntjac_pkg::*;

  localparam int Sets = 64;
  localparam int Ways = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         train_valid_i = 1'b0;
  branch_type_e train_branch_type_i = BRANCH_NONE;
  logic [63:0]  train_pc_i = '0;
  logic         train_partial_i = 1'b0;
  logic [63:0]  train_npc_i = '0;
  logic         train_taken_i = 1'b0;
  logic         access_valid_i = 1'b0;
  logic [63:0]  access_pc_i = '0;
  logic         access_hit_o;
  branch_type_e access_branch_type_o;
  logic         access_partial_o;
  logic [63:0]  access_npc_o;

  int n_checks = 0;
  int n_fail = 0;

  muntjac_btb_assoc dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .train_valid_i        (train_valid_i),
    .train_branch_type_i  (train_branch_type_i),
    .train_pc_i           (train_pc_i),
    .train_partial_i      (train_partial_i),
    .train_npc_i          (train_npc_i),
    .train_taken_i        (train_taken_i),
    .access_valid_i       (access_valid_i),
    .access_pc_i          (access_pc_i),
    .access_hit_o         (access_hit_o),
    .access_branch_type_o (access_branch_type_o),
    .access_partial_o     (access_partial_o),
    .access_npc_o         (access_npc_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: per set, a small table of remembered branches.
  bit          m_valid   [Sets][Ways];
  logic [63:0] m_tag     [Sets][Ways];
  logic [63:0] m_npc     [Sets][Ways];
  int          m_type    [Sets][Ways];
  bit          m_partial [Sets][Ways];
  int          m_cnt     [Sets][Ways];
  int          m_rr      [Sets];
  bit          e_hit;
  logic [63:0] e_npc;
  int          e_type;
  bit          e_partial;

  task automatic model_reset();
    for (int s = 0; s < Sets; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < Ways; w++) m_valid[s][w] = 0;
    end
    e_hit = 0; e_npc = '0; e_type = 0; e_partial = 0;
  endtask

  task automatic model_step(input bit fl, input bit tv, input logic [63:0] tpc, input logic [63:0] tnpc,
                            input int tty, input bit tpart, input bit ttk, input bit av, input logic [63:0] apc);
    int s, w, hw;
    logic [63:0] tag;
    if (av) begin
      e_hit = 0; e_npc = '0; e_type = 0; e_partial = 0;
      s = int'((apc >> 2) % Sets);
      tag = apc >> 8;
      for (w = 0; w < Ways; w++)
        if (!fl && m_valid[s][w] && m_tag[s][w] == tag
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
            && m_cnt[s][w] >= 2
`endif
           ) begin
          e_hit = 1; e_npc = m_npc[s][w]; e_type = m_type[s][w]; e_partial = m_partial[s][w];
        end
    end
    if (fl) begin
      for (int i = 0; i < Sets; i++) for (int j = 0; j < Ways; j++) m_valid[i][j] = 0;
      return;
    end
    if (!tv) return;
    s = int'((tpc >> 2) % Sets);
    tag = tpc >> 8;
    hw = -1;
    for (w = 0; w < Ways; w++) if (m_valid[s][w] && m_tag[s][w] == tag) hw = w;
`ifdef MUNTJAC_BTB_HYSTERESIS_EN
    if (hw >= 0) begin
      m_cnt[s][hw] = ttk ? ((m_cnt[s][hw] < 3) ? m_cnt[s][hw] + 1 : 3)
                         : ((m_cnt[s][hw] > 0) ? m_cnt[s][hw] - 1 : 0);
      if (!ttk) return;
    end else if (!ttk) return;
`endif
    if (hw < 0) begin
      for (w = Ways - 1; w >= 0; w--) if (!m_valid[s][w]) hw = w;
      if (hw < 0) begin
        hw = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % Ways;
      end
      m_cnt[s][hw] = 2;
    end
    m_valid[s][hw] = 1; m_tag[s][hw] = tag; m_npc[s][hw] = tnpc & ~64'd1;
    m_type[s][hw] = tty; m_partial[s][hw] = tpart;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: drive, clock, update the model, compare all outputs.
  task automatic applyStimulus(input bit fl, input bit tv, input logic [63:0] tpc, input logic [63:0] tnpc,
                               input int tty, input bit tpart, input bit ttk, input bit av, input logic [63:0] apc);
    flush_i = fl; train_valid_i = tv; train_pc_i = tpc; train_npc_i = tnpc;
    train_branch_type_i = branch_type_e'(tty); train_partial_i = tpart; train_taken_i = ttk;
    access_valid_i = av; access_pc_i = apc;
    @(posedge clk_i);
    #1;
    model_step(fl, tv, tpc, tnpc, tty, tpart, ttk, av, apc);
    checkOutput("hit", 64'(access_hit_o), 64'(e_hit));
    checkOutput("npc", access_npc_o, e_npc);
    checkOutput("type", 64'(access_branch_type_o), 64'(e_type));
    checkOutput("partial", 64'(access_partial_o), 64'(e_partial));
    flush_i = 0; train_valid_i = 0; access_valid_i = 0;
  endtask

  task automatic train(input logic [63:0] pc, input logic [63:0] npc, input bit tk);
    applyStimulus(0, 1, pc, npc, 1, 0, tk, 0, '0);
  endtask

  task automatic lookup(input string name, input logic [63:0] pc, input bit exp_hit);
    applyStimulus(0, 0, '0, '0, 0, 0, 0, 1, pc);
    checkOutput(name, 64'(access_hit_o), 64'(exp_hit));
  endtask

  logic [63:0] tags [5];

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    checkOutput("reset_hit", 64'(access_hit_o), 64'd0);

    lookup("empty_lookup", 64'h1000, 0);
    applyStimulus(0, 1, 64'h1000, 64'h2001, 3, 1, 1, 0, '0);
    lookup("train_then_hit", 64'h1000, 1);
    checkOutput("npc_bit0_cleared", access_npc_o, 64'h2000);
    checkOutput("stored_partial", 64'(access_partial_o), 64'd1);

    train(64'h1000, 64'h1111, 1);
    applyStimulus(1, 1, 64'h2000, 64'h2222, 2, 0, 1, 0, '0);
    lookup("flush_clears_A", 64'h1000, 0);
    lookup("flush_drops_train_B", 64'h2000, 0);

    train(64'h1000, 64'hA0, 1);
    train(64'h2000, 64'hB0, 1);
    train(64'h3000, 64'hC0, 1);
    lookup("C_evicts_A", 64'h1000, 0);
    lookup("B_kept", 64'h2000, 1);
    lookup("C_hits", 64'h3000, 1);
    train(64'h4000, 64'hD0, 1);
    lookup("D_evicts_B", 64'h2000, 0);
    lookup("C_still_hits", 64'h3000, 1);
    lookup("D_hits", 64'h4000, 1);

    applyStimulus(0, 1, 64'h7014, 64'h9000, 4, 0, 1, 1, 64'h7014);
    checkOutput("same_cycle_miss", 64'(access_hit_o), 64'd0);
    lookup("next_cycle_hit", 64'h7014, 1);
    applyStimulus(0, 0, '0, '0, 0, 0, 0, 0, '0);
    checkOutput("hold_when_idle", 64'(access_hit_o), 64'd1);

`ifdef MUNTJAC_BTB_HYSTERESIS_EN
    train(64'h5024, 64'h6000, 1);
    train(64'h5024, 64'h6100, 0);
    lookup("hyst_weak_miss", 64'h5024, 0);
    train(64'h5024, 64'h6200, 1);
    lookup("hyst_strong_hit", 64'h5024, 1);
    checkOutput("hyst_npc", access_npc_o, 64'h6200);
    train(64'h50A4, 64'h6300, 0);
    lookup("hyst_nt_no_alloc", 64'h50A4, 0);
`endif

    for (int i = 0; i < 5; i++) tags[i] = {$urandom(), $urandom()} >> 8;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] tpc, apc, tnpc;
      tpc  = (tags[$urandom_range(0, 4)] << 8) | 64'($urandom_range(0, 3) << 2) | 64'($urandom_range(0, 3));
      apc  = (tags[$urandom_range(0, 4)] << 8) | 64'($urandom_range(0, 3) << 2) | 64'($urandom_range(0, 3));
      tnpc = {$urandom(), $urandom()};
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, tpc, tnpc,
                    $urandom_range(0, 5), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, apc);
    end

    train(64'h8000, 64'h8800, 1);
    lookup("pre_reset_hit", 64'h8000, 1);
    flush_i = 0; train_valid_i = 1; train_pc_i = 64'h9000; train_taken_i = 1;
    access_valid_i = 1; access_pc_i = 64'h8000;
    #3 rst_ni = 0;
    #1;
    model_reset();
    checkOutput("async_reset_hit", 64'(access_hit_o), 64'd0);
    checkOutput("async_reset_npc", access_npc_o, 64'd0);
    train_valid_i = 0; access_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    lookup("reset_discards_entry", 64'h8000, 0);
    lookup("reset_drops_train", 64'h9000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
